multi_num_writer: RTL and testbench

- N-digit BCD up/down counter that renders its value into the LED-matrix column frame buffer, one 32-bit column write per cycle.
- Sits between the button front end (debounce + single_pulser, already instantiated upstream) and the frame-buffer write port.
- Glyph lookup goes through the existing digit_generator.
- Generalises the single-digit writer with:
  - parametrised digit count, column count and placement;
  - decrement and clear;
  - leading-zero blanking;
  - explicit refresh;
  - coalescing of events that arrive mid-redraw.

---
 rtl/multi_num_writer.sv | 163 ++++++++++++++++
 tb/tb_multi_num_writer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_num_writer.sv
// rtl/multi_num_writer.sv - N-digit BCD up/down counter that redraws its value into the LED column frame buffer
module multi_num_writer #(
    parameter int N_DIGITS       = 2,
    parameter int COLS_PER_DIGIT = 6,
    parameter int DIGIT_STRIDE   = 6,
    parameter int BASE_ADDR      = 172,
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_pulse,
    input  logic                  dec_pulse,
    input  logic                  clr_pulse,
    input  logic                  refresh_pulse,
    input  logic                  blank_lz,
    input  logic [2:0]            num_color,
    output logic [3:0]            glyph_num,
    output logic [2:0]            glyph_col,
    output logic [2:0]            glyph_color,
    input  logic [DATA_W-1:0]     glyph_data,
    output logic                  numcol_we,
    output logic [ADDR_W-1:0]     numcol_addr,
    output logic [DATA_W-1:0]     numcol_out,
    output logic                  busy,
    output logic [4*N_DIGITS-1:0] value
);

    localparam int VW = 4 * N_DIGITS;
    localparam logic [2:0] LAST_C = 3'(COLS_PER_DIGIT - 1);
    localparam logic [1:0] LAST_D = 2'(N_DIGITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    state_t          state_q;
    logic [VW-1:0]   value_q, value_d;
    logic [VW-1:0]   draw_val_q;
    logic            pending_q, pending_d;
    logic [1:0]      d_q;
    logic [2:0]      c_q;
    logic            event_w;
    logic            blank_cur;
    logic            all_zero;
    logic [3:0]      dig;

    // Nibble 0 of the vector is the least significant digit (digit N_DIGITS-1).
    function automatic logic [VW-1:0] bcd_inc(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign event_w = inc_pulse | dec_pulse | clr_pulse | refresh_pulse;

    always_comb begin
        value_d = value_q;
        if (clr_pulse) begin
            value_d = '0;
        end else if (inc_pulse && !dec_pulse) begin
            value_d = bcd_inc(value_q);
        end else if (dec_pulse && !inc_pulse) begin
            value_d = bcd_dec(value_q);
        end
    end

    // A pending redraw is consumed only when IDLE launches a draw; events always re-arm it.
    assign pending_d = event_w | (pending_q & (state_q == DRAW));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            value_q    <= '0;
            draw_val_q <= '0;
            pending_q  <= 1'b1;
            d_q        <= '0;
            c_q        <= '0;
        end else begin
            value_q   <= value_d;
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        state_q    <= DRAW;
                        draw_val_q <= value_q;
                        d_q        <= '0;
                        c_q        <= '0;
                    end
                end
                DRAW: begin
                    if (c_q == LAST_C) begin
                        c_q <= '0;
                        if (d_q == LAST_D) begin
                            state_q <= IDLE;
                        end else begin
                            d_q <= d_q + 2'd1;
                        end
                    end else begin
                        c_q <= c_q + 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Walk digits from most significant; a digit is blank while every digit so far is zero.
    always_comb begin
        glyph_num = '0;
        blank_cur = 1'b0;
        all_zero  = 1'b1;
        dig       = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            dig      = draw_val_q[4*(N_DIGITS-1-i) +: 4];
            all_zero = all_zero & (dig == 4'd0);
            if (d_q == 2'(i)) begin
                glyph_num = dig;
                blank_cur = blank_lz & all_zero & (i < N_DIGITS - 1);
            end
        end
    end

    assign glyph_col   = c_q;
    assign glyph_color = num_color;
    assign numcol_we   = (state_q == DRAW);
    assign busy        = (state_q == DRAW);
    assign numcol_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(d_q) * ADDR_W'(DIGIT_STRIDE) + ADDR_W'(c_q);
    assign numcol_out  = blank_cur ? '0 : glyph_data;
    assign value       = value_q;

endmodule

// File: tb/tb_multi_num_writer.sv
// tb/tb_multi_num_writer.sv - scoreboard bench for multi_num_writer (default and 3-digit stride-8 instances)
module tb_multi_num_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inc = 1'b0, dec = 1'b0, clr = 1'b0, refr = 1'b0, blz = 1'b0;
    logic [2:0]  color = 3'd5;
    logic [3:0]  gnum;
    logic [2:0]  gcol, gcolor;
    logic [31:0] gdata;
    logic        we, busy;
    logic [9:0]  addr;
    logic [31:0] dout;
    logic [7:0]  val;

    logic        rst3 = 1'b0, inc3 = 1'b0, blz3 = 1'b0;
    logic [3:0]  gnum3;
    logic [2:0]  gcol3, gcolor3;
    logic [31:0] gdata3;
    logic        we3, busy3;
    logic [9:0]  addr3;
    logic [31:0] dout3;
    logic [11:0] val3;

    logic [41:0] q0[$];
    logic [41:0] q1[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] gfun(input logic [3:0] n, input logic [2:0] c, input logic [2:0] k);
        logic [7:0] t;
        t = {4'b0, n} * 8'd17 + {5'b0, c};
        return {8'hC3, n, 1'b0, c, 1'b0, k, ~n, t};
    endfunction

    assign gdata  = gfun(gnum, gcol, gcolor);
    assign gdata3 = gfun(gnum3, gcol3, gcolor3);

    multi_num_writer dut (
        .clk(clk), .rst(rst), .inc_pulse(inc), .dec_pulse(dec), .clr_pulse(clr),
        .refresh_pulse(refr), .blank_lz(blz), .num_color(color),
        .glyph_num(gnum), .glyph_col(gcol), .glyph_color(gcolor), .glyph_data(gdata),
        .numcol_we(we), .numcol_addr(addr), .numcol_out(dout), .busy(busy), .value(val)
    );

    multi_num_writer #(.N_DIGITS(3), .DIGIT_STRIDE(8)) dut3 (
        .clk(clk), .rst(rst3), .inc_pulse(inc3), .dec_pulse(1'b0), .clr_pulse(1'b0),
        .refresh_pulse(1'b0), .blank_lz(blz3), .num_color(color),
        .glyph_num(gnum3), .glyph_col(gcol3), .glyph_color(gcolor3), .glyph_data(gdata3),
        .numcol_we(we3), .numcol_addr(addr3), .numcol_out(dout3), .busy(busy3), .value(val3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_draw(input int which, input logic [15:0] v, input logic bl, input int nd, input int stride);
        logic       allz;
        logic [3:0] dg;
        logic [9:0] a;
        logic [31:0] dat;
        allz = 1'b1;
        for (int d = 0; d < nd; d++) begin
            dg   = v[4*(nd-1-d) +: 4];
            allz = allz & (dg == 4'd0);
            for (int c = 0; c < 6; c++) begin
                a   = 10'(172 + d * stride + c);
                dat = (bl && allz && d < nd - 1) ? 32'd0 : gfun(dg, 3'(c), 3'd5);
                if (which == 0) q0.push_back({a, dat});
                else            q1.push_back({a, dat});
            end
        end
    endtask

    always @(negedge clk) begin
        logic [41:0] e;
        if (we === 1'b1) begin
            if (q0.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL m0_unexpected: got write addr %0d expected no write", addr);
            end else begin
                e = q0.pop_front();
                chk("m0_addr", 64'(addr), 64'(e[41:32]));
                chk("m0_data", 64'(dout), 64'(e[31:0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [41:0] e;
        if (we3 === 1'b1) begin
            if (q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL m1_unexpected: got write addr %0d expected no write", addr3);
            end else begin
                e = q1.pop_front();
                chk("m1_addr", 64'(addr3), 64'(e[41:32]));
                chk("m1_data", 64'(dout3), 64'(e[31:0]));
            end
        end
    end

    task automatic wait_quiet(input int which);
        int quiet, n;
        quiet = 0;
        n     = 0;
        while (quiet < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (((which == 0) ? busy : busy3) === 1'b0) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_quiet_timeout: got busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic pulse(input int kind);
        @(posedge clk);
        #1;
        inc  = (kind == 0 || kind == 4);
        dec  = (kind == 1 || kind == 4);
        clr  = (kind == 2);
        refr = (kind == 3);
        @(posedge clk);
        #1;
        inc = 0; dec = 0; clr = 0; refr = 0;
    endtask

    task automatic step(input int kind, input logic [7:0] exp);
        push_draw(0, 16'(exp), blz, 2, 6);
        pulse(kind);
        chk("step_value", 64'(val), 64'(exp));
        wait_quiet(0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 64'(we), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_value", 64'(val), 64'(0));
        chk("rst3_we", 64'(we3), 64'(0));

        push_draw(0, 16'h00, 1'b0, 2, 6);
        push_draw(1, 16'h000, 1'b0, 3, 8);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        rst3 = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (busy === 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("reset_busy_len", 64'(n), 64'(12));
        wait_quiet(0);
        wait_quiet(1);
        chk("reset_value", 64'(val), 64'(0));
        chk("reset3_drained", 64'(q1.size()), 64'(0));

        for (int i = 1; i <= 9; i++) step(0, 8'(i));

        push_draw(0, 16'h10, 1'b0, 2, 6);
        @(posedge clk);
        #1 inc = 1;
        @(posedge clk);
        #1 inc = 0;
        chk("lat_value", 64'(val), 64'h10);
        chk("lat_we_t1", 64'(we), 64'(0));
        @(posedge clk);
        #1;
        chk("lat_we_t2", 64'(we), 64'(1));
        chk("lat_addr", 64'(addr), 64'(172));
        chk("lat_gnum", 64'(gnum), 64'(1));
        wait_quiet(0);

        step(2, 8'h00);
        step(1, 8'h99);
        step(0, 8'h00);
        step(4, 8'h00);

        for (int i = 1; i <= 7; i++) step(0, 8'(i));
        blz = 1'b1;
        step(3, 8'h07);
        step(2, 8'h00);
        blz = 1'b0;

        for (int i = 1; i <= 5; i++) step(0, 8'(i));
        push_draw(0, 16'h05, 1'b0, 2, 6);
        push_draw(0, 16'h08, 1'b0, 2, 6);
        pulse(3);
        n = 0;
        while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 inc = 1;
            @(posedge clk);
            #1 inc = 0;
            repeat (1) @(posedge clk);
        end
        wait_quiet(0);
        chk("coalesce_value", 64'(val), 64'h08);
        chk("coalesce_drained", 64'(q0.size()), 64'(0));

        push_draw(0, 16'h08, 1'b0, 2, 6);
        pulse(3);
        n = 0;
        while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_we", 64'(we), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_value", 64'(val), 64'(0));
        chk("abort_left", 64'(q0.size()), 64'(7));
        q0.delete();
        push_draw(0, 16'h00, 1'b0, 2, 6);
        @(posedge clk);
        #1 rst = 1'b1;
        wait_quiet(0);
        chk("abort_redraw_drained", 64'(q0.size()), 64'(0));

        blz3 = 1'b1;
        push_draw(1, 16'h001, 1'b1, 3, 8);
        @(posedge clk);
        #1 inc3 = 1;
        @(posedge clk);
        #1 inc3 = 0;
        chk("d3_value", 64'(val3), 64'h001);
        wait_quiet(1);
        chk("d3_drained", 64'(q1.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
